// File: rtl/bitstream_pkg.sv
// Shared definitions for the bitstream sequencer: FSM state encoding,
// source indices, writer port widths and a state-to-source helper.
package bitstream_pkg;

    localparam int NUM_SRC = 3;
    localparam int VAL_W   = 64;
    localparam int SIZE_W  = 64;

    localparam logic [1:0] SRC_FRAME = 2'd0;
    localparam logic [1:0] SRC_PIC   = 2'd1;
    localparam logic [1:0] SRC_SLICE = 2'd2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FRAME = 3'd1;
    localparam logic [2:0] ST_PIC   = 3'd2;
    localparam logic [2:0] ST_SLICE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic logic is_src_state(input logic [2:0] st);
        return (st == ST_FRAME) || (st == ST_PIC) || (st == ST_SLICE);
    endfunction

    function automatic logic [1:0] state_src(input logic [2:0] st);
        logic [1:0] s;
        s = SRC_FRAME;
        if (st == ST_PIC)   s = SRC_PIC;
        if (st == ST_SLICE) s = SRC_SLICE;
        return s;
    endfunction

endpackage

// File: rtl/bitwriter_mux.sv
// Registered N:1 mux of the bit-writer port (enable/val/size/flush).
// Ports: clock, reset (async high); sel/sel_valid pick the active source,
// kill suppresses forwarding for one cycle; in_* are the packed source
// ports; fwd_enable/fwd_size expose the word being registered this cycle;
// stray flags an enable from a non-active source; out_* are registered.
module bitwriter_mux
    import bitstream_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                sel,
    input  logic                      sel_valid,
    input  logic                      kill,
    input  logic [NUM_SRC-1:0]        in_enable,
    input  logic [NUM_SRC*VAL_W-1:0]  in_val,
    input  logic [NUM_SRC*SIZE_W-1:0] in_size,
    input  logic [NUM_SRC-1:0]        in_flush,
    output logic                      fwd_enable,
    output logic [SIZE_W-1:0]         fwd_size,
    output logic                      stray,
    output logic                      out_enable,
    output logic [VAL_W-1:0]          out_val,
    output logic [SIZE_W-1:0]         out_size,
    output logic                      out_flush
);

    logic [NUM_SRC-1:0] mask;
    logic               pick_en;
    logic               pick_flush;
    logic [VAL_W-1:0]   pick_val;
    logic [SIZE_W-1:0]  pick_size;

    always_comb begin
        mask       = '0;
        pick_en    = 1'b0;
        pick_flush = 1'b0;
        pick_val   = '0;
        pick_size  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            mask[i] = sel_valid && (sel == 2'(i));
            if (mask[i] && !kill) begin
                pick_en    = in_enable[i];
                pick_flush = in_flush[i];
                pick_val   = in_val[i*VAL_W +: VAL_W];
                pick_size  = in_size[i*SIZE_W +: SIZE_W];
            end
        end
    end

    // Outside a source state no lane is active, so any enable is stray.
    assign stray      = |(in_enable & ~mask);
    assign fwd_enable = pick_en;
    assign fwd_size   = pick_size;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_enable <= 1'b0;
            out_val    <= '0;
            out_size   <= '0;
            out_flush  <= 1'b0;
        end else begin
            out_enable <= pick_en;
            out_val    <= pick_val;
            out_size   <= pick_size;
            out_flush  <= pick_flush;
        end
    end

endmodule

// File: rtl/bitstream_sequencer.sv
// Frame scheduler: runs frame header, picture header and N slices in order,
// muxes their writer ports onto one packer input, counts bits, and aborts
// on a stalled source. Ports: clock, reset, start, num_slices, busy,
// frame_done, error, src_start/done/enable/val/size/flush, output_enable,
// val, size_of_bit, flush_bit, bits_written.
module bitstream_sequencer
    import bitstream_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [15:0]               num_slices,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      error,
    output logic [NUM_SRC-1:0]        src_start,
    input  logic [NUM_SRC-1:0]        src_done,
    input  logic [NUM_SRC-1:0]        src_enable,
    input  logic [NUM_SRC*VAL_W-1:0]  src_val,
    input  logic [NUM_SRC*SIZE_W-1:0] src_size,
    input  logic [NUM_SRC-1:0]        src_flush,
    output logic                      output_enable,
    output logic [VAL_W-1:0]          val,
    output logic [SIZE_W-1:0]         size_of_bit,
    output logic                      flush_bit,
    output logic [CNT_W-1:0]          bits_written
);

    logic [2:0]       state;
    logic [15:0]      nslices;
    logic [15:0]      slice_idx;
    logic [CNT_W-1:0] wdog;

    logic              in_src;
    logic [1:0]        act;
    logic              timeout;
    logic              done_hit;
    logic              fwd_enable;
    logic [SIZE_W-1:0] fwd_size;
    logic              stray;

    assign in_src   = is_src_state(state);
    assign act      = state_src(state);
    assign timeout  = in_src && (wdog == CNT_W'(TIMEOUT_CYCLES - 1));
    // The abort wins over a completion arriving in the same cycle.
    assign done_hit = in_src && src_done[act] && !timeout;

    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE);

    bitwriter_mux u_mux (
        .clock      (clock),
        .reset      (reset),
        .sel        (act),
        .sel_valid  (in_src),
        .kill       (timeout),
        .in_enable  (src_enable),
        .in_val     (src_val),
        .in_size    (src_size),
        .in_flush   (src_flush),
        .fwd_enable (fwd_enable),
        .fwd_size   (fwd_size),
        .stray      (stray),
        .out_enable (output_enable),
        .out_val    (val),
        .out_size   (size_of_bit),
        .out_flush  (flush_bit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            nslices      <= '0;
            slice_idx    <= '0;
            wdog         <= '0;
            error        <= 1'b0;
            bits_written <= '0;
            src_start    <= '0;
        end else begin
            src_start <= '0;
            if (in_src) wdog <= wdog + 1'b1;
            if (fwd_enable) bits_written <= bits_written + CNT_W'(fwd_size);
            if (stray) error <= 1'b1;

            if (timeout) begin
                state <= ST_IDLE;
                error <= 1'b1;
                wdog  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state        <= ST_FRAME;
                            nslices      <= num_slices;
                            slice_idx    <= '0;
                            bits_written <= '0;
                            error        <= stray;
                            wdog         <= '0;
                            src_start    <= 3'b001;
                        end
                    end
                    ST_FRAME: begin
                        if (done_hit) begin
                            state     <= ST_PIC;
                            wdog      <= '0;
                            src_start <= 3'b010;
                        end
                    end
                    ST_PIC: begin
                        if (done_hit) begin
                            wdog <= '0;
                            if (nslices == 16'd0) begin
                                state <= ST_DONE;
                            end else begin
                                state     <= ST_SLICE;
                                slice_idx <= '0;
                                src_start <= 3'b100;
                            end
                        end
                    end
                    ST_SLICE: begin
                        if (done_hit) begin
                            wdog <= '0;
                            if (slice_idx == nslices - 16'd1) begin
                                state <= ST_DONE;
                            end else begin
                                slice_idx <= slice_idx + 16'd1;
                                src_start <= 3'b100;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/bitstream_sequencer.md
Name: bitstream_sequencer

Overview:
Top-level frame scheduler for the encoder's output bitstream. It starts the frame header, picture header and slice generators in strict order, and runs the slice source once per slice. It multiplexes their bit-writer streams (enable/val/size/flush) onto the single bit-packer input and counts the bits emitted. A watchdog aborts the frame if any source stalls.

Parameters:
NUM_SRC, 3, number of sources: 0 = frame header, 1 = picture header, 2 = slice; fixed at 3, not user-scalable.
TIMEOUT_CYCLES, 65535, maximum cycles spent in any source state before abort.
CNT_W, 32, width of bits_written and of the watchdog counter.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle frame start request
num_slices  in  16  slices per picture; sampled on accepted start
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse on normal frame completion
error  out  1  sticky watchdog/protocol error; cleared on accepted start
src_start  out  3  one-cycle start pulse per source
src_done  in  3  per-source completion pulse
src_enable  in  3  per-source write strobe
src_val  in  192  per-source value; source i uses bits [64i+63:64i]
src_size  in  192  per-source bit count; same packing as src_val
src_flush  in  3  per-source flush request
output_enable  out  1  write strobe to bit packer
val  out  64  value to bit packer
size_of_bit  out  64  bit count to bit packer
flush_bit  out  1  flush to bit packer
bits_written  out  32  running sum of forwarded size_of_bit[31:0]

Behaviour:
- Reset: all outputs 0, state IDLE, slice_idx 0, watchdog 0.
- States: IDLE, FRAME_HDR, PIC_HDR, SLICE, DONE.
- IDLE:
  - start=1 -> FRAME_HDR.
  - Same edge: latch num_slices, clear bits_written and error.
  - src_start[0]=1 in the first FRAME_HDR cycle.
- FRAME_HDR:
  - src_done[0] -> PIC_HDR.
  - src_start[1] pulses in the first PIC_HDR cycle.
- PIC_HDR:
  - src_done[1] with latched num_slices=0 -> DONE (slice source never started).
  - Otherwise -> SLICE, slice_idx=0, src_start[2] pulses in the first SLICE cycle.
- SLICE:
  - src_done[2] with slice_idx==num_slices-1 -> DONE.
  - Otherwise slice_idx++, stay in SLICE, and re-pulse src_start[2] on the next cycle.
- DONE: frame_done=1 for exactly one cycle -> IDLE.
- start while busy: ignored; no effect on latched num_slices or counters.
- Mux:
  - Outputs are registered, with 1-cycle latency from the active source's inputs.
  - The active source is the one owning the current state.
  - An enable in the same cycle as that source's done is still forwarded.
  - Outside source states (IDLE, DONE) and for non-active sources: output_enable=0, val=0, size_of_bit=0, flush_bit=0.
  - src_enable asserted by a non-active source sets error (sticky); its data is dropped.
- bits_written:
  - Adds size_of_bit[31:0] on every forwarded write, in the same cycle output_enable is driven.
  - Wraps modulo 2^32.
- Watchdog:
  - Clears on every state entry and on each src_start pulse; increments each cycle in a source state.
  - At TIMEOUT_CYCLES: error=1, state -> IDLE, no frame_done, src outputs 0.
  - src_done arriving in that same cycle loses to the abort.
- src_done from a non-active source: ignored, no error.
- Reset mid-frame: immediate return to IDLE with all outputs 0; no frame_done.

Decomposition:
- Shared package bitstream_pkg:
  - State encoding.
  - Source index constants SRC_FRAME=0, SRC_PIC=1, SRC_SLICE=2.
  - Writer port widths VAL_W=64, SIZE_W=64.
- One sub-module: bitwriter_mux, a registered N:1 mux of the writer port with a select input and a stray-enable detect output.
- FSM, slice counter, watchdog and bits_written stay in the top module.

Test Plan:
- Nominal frame: num_slices=2; each source emits 2 writes of size 8 then done.
  -> src_start order 0,1,2,2.
  -> 8 forwarded writes, each 1 cycle after its input.
  -> bits_written=64.
  -> single frame_done pulse.
- num_slices=0: frame and picture headers complete -> src_start[2] never pulses; frame_done 1 cycle after src_done[1] is sampled.
- Stray enable: src_enable[2]=1 with val=0xAB during PIC_HDR -> no output write, error=1 and held; the next accepted start clears error.
- Timeout: TIMEOUT_CYCLES=16; frame source never signals done -> error=1 after 16 cycles in FRAME_HDR, busy=0, no frame_done.
- Start while busy plus wrap: start pulsed mid-SLICE -> ignored. Preload bits_written near 2^32 via writes of 0xFFFFFFF0 then 0x20 -> wraps to 0x10.
- Reset mid-frame: assert reset during SLICE with output_enable=1 -> all outputs 0 asynchronously; after release, state IDLE and busy=0.
